// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared op codes, FSM states and operand-signedness helpers
// Contents: MD_* funct3 codes, md_state_e FSM encoding, op_a_signed/op_b_signed.
package muldiv_seq_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM (MULHSU treats it as unsigned).
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - shift-add multiply / restoring divide datapath with sign fix-up
// Ports: clk, rst (async high); load/load_div/a_mag/b_mag start an op;
//        step advances one bit; op/sign_a/sign_b select the fix-up; fixed is the final result.
module muldiv_core
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            load_div,
    input  logic            step,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    input  logic [2:0]      op,
    input  logic            sign_a,
    input  logic            sign_b,
    output logic [XLEN-1:0] fixed
);

    // acc holds {product high, multiplier} for multiply and {remainder, quotient} for divide.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
        div_rem   = div_shift[XLEN-1:0] - opnd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{XLEN{1'b0}}, (load_div ? a_mag : b_mag)};
            opnd <= load_div ? b_mag : a_mag;
        end else if (step) begin
            if (op[2]) begin
                acc <= {(div_ge ? div_rem : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
            end else begin
                acc <= {mul_sum, acc[XLEN-1:1]};
            end
        end
    end

    assign quo    = acc[XLEN-1:0];
    assign rem    = acc[2*XLEN-1:XLEN];
    assign prod_s = (sign_a ^ sign_b) ? -acc : acc;

    always_comb begin
        fixed = '0;
        if (!op[2]) begin
            fixed = (op == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (op[1]) begin
            fixed = sign_a ? -rem : rem;
        end else begin
            fixed = (sign_a ^ sign_b) ? -quo : quo;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - RV32M multiply/divide sequencer with pipeline stall handshake
// Ports: clk, rst (async high); start/op/a/b request an M-op; flush kills it;
//        stall holds the pipeline; busy = op in flight; done pulses with a valid result.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            sign_a_q;
    logic            sign_b_q;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_val;
    logic            accept;
    logic            step;
    logic [XLEN-1:0] fixed;

    always_comb begin
        a_neg    = op_a_signed(op) & a[XLEN-1];
        b_neg    = op_b_signed(op) & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = op[2] && (b == '0);
        div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (a == SMIN) && (b == '1);
        // Divide by zero: quotient all ones, remainder = dividend.
        // Overflow: quotient = dividend (most negative value), remainder 0.
        if (div_zero) begin
            special_val = op[1] ? a : '1;
        end else begin
            special_val = op[1] ? '0 : SMIN;
        end
    end

    assign accept = (state == MD_IDLE) && start && !flush;
    assign step   = (state == MD_ITER) && !flush;
    assign stall  = busy | accept;

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_div (op[2]),
        .step     (step),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .op       (op_q),
        .sign_a   (sign_a_q),
        .sign_b   (sign_b_q),
        .fixed    (fixed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            op_q     <= MD_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else if (flush) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        sign_a_q <= a_neg;
                        sign_b_q <= b_neg;
                        cnt      <= '0;
                        if (div_zero || div_ovf) begin
                            result <= special_val;
                            state  <= MD_DONE;
                            done   <= 1'b1;
                        end else begin
                            state <= MD_ITER;
                            busy  <= 1'b1;
                        end
                    end
                end
                MD_ITER: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XLEN - 1)) begin
                        state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    result <= fixed;
                    state  <= MD_DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against an arithmetic reference
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed directly with 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx;
        longint sy;
        longint ux;
        longint uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        p  = '0;
        case (o)
            3'd0: begin p = ux * uy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hffff_ffff;
                if (x == 32'h8000_0000 && y == 32'hffff_ffff) return 32'h8000_0000;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hffff_ffff;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hffff_ffff) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    // Issues a request in the current (negedge-aligned) cycle and follows it to DONE.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] exp;
        bit          spec;
        int          lat;
        int          bad;
        exp  = ref_model(o, x, y);
        spec = o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hffff_ffff));
        start = 1'b1; op = o; a = x; b = y;
        #1 check($sformatf("op%0d stall_req", o), stall, 1);
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        bad = 0;
        while (!done && lat < 100) begin
            if (!stall || !busy) bad++;
            @(negedge clk);
            lat++;
        end
        check($sformatf("op%0d latency", o), lat, spec ? 1 : 34);
        check($sformatf("op%0d result a=%0h b=%0h", o, x, y), result, exp);
        check($sformatf("op%0d stall_at_done", o), stall, 0);
        check($sformatf("op%0d hold_cycles_bad", o), bad, 0);
        @(negedge clk);
        check($sformatf("op%0d done_one_cycle", o), done, 0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        issue(o, x, y);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hffff_ffff;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  d_op [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd5, 3'd6, 3'd4, 3'd6, 3'd7, 3'd4};
    logic [31:0] d_a  [14] = '{32'd7, 32'h8000_0000, 32'hffff_ffff, 32'hffff_ffff,
                               32'hffff_fff9, 32'hffff_fff9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd20};
    logic [31:0] d_b  [14] = '{32'hffff_fffd, 32'h8000_0000, 32'hffff_ffff, 32'd2,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hffff_ffff, 32'hffff_ffff, 32'd0, 32'hffff_fffb};

    initial begin
        logic [31:0] held;
        bit          dseen;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset stall", stall, 0);
        check("reset result", result, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_op(d_op[i], d_a[i], d_b[i]);

        held = result;
        repeat (3) @(negedge clk);
        check("result_hold", result, held);

        // Flush a MUL at cycle k+10, then accept a DIVU in cycle k+11.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        dseen = 1'b0;
        repeat (9) begin
            @(negedge clk);
            dseen |= done;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush done", done | dseen, 0);
        issue(3'd5, 32'd9, 32'd3);

        // Asynchronous reset in the middle of ITER.
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        dseen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            dseen |= done;
        end
        check("rst_mid no_done", dseen, 0);

        // start together with flush in IDLE must not be accepted.
        start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        #1 check("start_flush stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush busy", busy, 0);
        check("start_flush done", done, 0);

        for (int i = 0; i < 40; i++) run_op(3'($urandom), pick(), pick());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
